mem_load_unit: RTL
==================

Name: mem_load_unit

Overview:
- Read-side counterpart of the MEM-stage store-data path: executes RV32I loads (LB/LH/LW/LBU/LHU) against a data-memory port with variable ack latency.
- Issues a word-aligned read request and stalls the pipeline until ack or timeout.
- Extracts and sign/zero-extends the addressed byte or halfword, then hands the result to MEM/WB.
- Sits in the MEM stage, beside the store-data forwarding mux.

Parameters:
- MAX_WAIT, 15: cycles spent in WAIT without ack before the load is aborted with bus_err_o (1..255).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read_i  input  1  from ex_mem: the instruction in MEM is a load.
- funct3_i  input  3  from ex_mem: load type.
- addr_i  input  32  from ex_mem: effective byte address.
- mem_req_o  output  1  read request to data memory.
- mem_addr_o  output  32  word address to memory, {addr[31:2],2'b00}.
- mem_ack_i  input  1  memory returns mem_rdata_i this cycle.
- mem_rdata_i  input  32  memory read word.
- stall_o  output  1  freeze PC/IF/ID/EX/MEM pipeline registers.
- load_data_o  output  32  extended load result, registered.
- load_valid_o  output  1  one-cycle pulse: load_data_o is valid.
- misalign_o  output  1  load is misaligned or has an illegal funct3; no request is issued.
- bus_err_o  output  1  one-cycle pulse: load timed out.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, wait_cnt=0.
  - load_data_o=0, load_valid_o=0, bus_err_o=0.
  - While rst is high, mem_req_o and stall_o are forced to 0.
  - Reset in any state, including WAIT, abandons the load; a late ack is ignored.
- Decode (combinational from funct3_i, addr_i[1:0]):
  - 000 LB, 100 LBU: any alignment.
  - 001 LH, 101 LHU: addr[0] must be 0.
  - 010 LW: addr[1:0] must be 00.
  - 011/110/111 are illegal.
  - bad = misaligned or illegal.
- IDLE:
  - mem_read_i=1 and bad=0:
    - mem_req_o=1 and stall_o=1 (combinational).
    - Latch funct3 and addr[1:0]; next state WAIT; wait_cnt=0.
  - mem_read_i=1 and bad=1: misalign_o=1 (combinational), no request, stall_o=0, stay in IDLE.
  - In IDLE, mem_ack_i is ignored.
- WAIT:
  - mem_req_o=1, stall_o=1; mem_addr_o uses the latched address.
  - mem_ack_i=1: load_data_o<=extract(mem_rdata_i), load_valid_o<=1, next state DONE.
  - No ack and wait_cnt==MAX_WAIT-1: load_data_o<=0, bus_err_o<=1, next state DONE.
  - Otherwise wait_cnt++.
  - Ack in the timeout cycle wins: data is returned and bus_err_o stays 0.
- DONE:
  - mem_req_o=0, stall_o=0; the pipeline advances at the end of this cycle.
  - load_valid_o or bus_err_o is high only in this cycle.
  - Next state is IDLE unconditionally. mem_read_i is ignored here because it still belongs to the completing load.
- Extraction uses the latched a=addr[1:0]:
  - LB: sign-extend byte a.
  - LBU: zero-extend byte a.
  - LH: sign-extend halfword a[1] (bits 15:0 or 31:16).
  - LHU: zero-extend that halfword.
  - LW: full word.
  - Byte a is mem_rdata_i[8a+7:8a] (little-endian).
- Latency: minimum 2 stall cycles (IDLE + one WAIT cycle with ack); result appears in the DONE cycle.
- Back-to-back loads: the second load's request is issued in the IDLE cycle following DONE.
- load_data_o holds its value until the next ack or timeout.
- mem_addr_o is combinational from addr_i in IDLE and from the latched address otherwise.

Test Plan:
- LB, addr=0x1003, ack on the first WAIT cycle with rdata=0x80FF_1234 → stall high for 2 cycles; in DONE load_data_o=0xFFFF_FF80, load_valid_o=1; mem_addr_o=0x1000.
- LHU, addr=0x2002, ack after 3 WAIT cycles with rdata=0xBEEF_0001 → stall for 4 cycles, load_data_o=0x0000_BEEF; LW of the same word → 0xBEEF_0001.
- LW, addr=0x3001 → misalign_o=1, mem_req_o=0, stall_o=0. Same for funct3=011 with addr=0x3000.
- MAX_WAIT=4, no ack → 4 WAIT cycles, then DONE with bus_err_o=1, load_data_o=0, load_valid_o=0. Ack arriving on the 4th WAIT cycle → valid data, no error.
- Two consecutive LW loads (0x10, 0x14), each acked on the first WAIT cycle → requests in cycles 0 and 3; two valid pulses; no request in the DONE cycle.
- rst asserted on the second WAIT cycle, ack arriving the next cycle → state IDLE, no valid pulse, load_data_o=0, stall_o=0.

Source files
------------

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues a word-aligned read for LB/LH/LW/LBU/LHU, stalls until
// ack or timeout, then returns the sign/zero-extended result to MEM/WB.
module mem_load_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic        bad;
  logic        accept;
  logic        timeout;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] extracted;

  always_comb begin
    bad = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr_i[0];
      3'b010:         bad = |addr_i[1:0];
      default:        bad = 1'b1;
    endcase
  end

  assign accept  = (state == S_IDLE) && mem_read_i && !bad;
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  // Extraction always works from the latched funct3/offset, never the live ex_mem inputs.
  always_comb begin
    sel_byte  = 8'(mem_rdata_i >> {lat_addr[1:0], 3'b000});
    sel_half  = lat_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    extracted = mem_rdata_i;
    case (lat_f3)
      3'b000:  extracted = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  extracted = {24'd0, sel_byte};
      3'b001:  extracted = {{16{sel_half[15]}}, sel_half};
      3'b101:  extracted = {16'd0, sel_half};
      default: extracted = mem_rdata_i;
    endcase
  end

  always_comb begin
    next_state = state;
    mem_req_o  = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    mem_addr_o = {lat_addr[31:2], 2'b00};
    case (state)
      S_IDLE: begin
        mem_addr_o = {addr_i[31:2], 2'b00};
        misalign_o = mem_read_i && bad;
        if (accept) begin
          mem_req_o  = 1'b1;
          stall_o    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i || timeout) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (rst) begin
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
    end
  end

  // An ack in the timeout cycle takes priority, so data wins over bus_err_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 8'd0;
      lat_f3       <= 3'd0;
      lat_addr     <= 32'd0;
      load_data_o  <= 32'd0;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state        <= next_state;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_f3   <= funct3_i;
            lat_addr <= addr_i;
            wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            load_data_o  <= extracted;
            load_valid_o <= 1'b1;
          end else if (timeout) begin
            load_data_o <= 32'd0;
            bus_err_o   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
